// File: rtl/float_mul_arbiter.sv
// Round-robin arbiter sharing one float_mul among N_REQ requesters.
// Operands are latched at grant, and a timeout returns a quiet NaN flagged with err.
module float_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [32*N_REQ-1:0]   op_a,
  input  logic [32*N_REQ-1:0]   op_b,
  output logic [N_REQ-1:0]      done,
  output logic [31:0]           result,
  output logic                  err,
  output logic                  busy,
  output logic                  mul_start,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_result,
  input  logic                  mul_ready
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [GW-1:0] rr_ptr_reg;
  logic [GW-1:0] grant_reg;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   mul_a_reg, mul_b_reg, result_reg;
  logic          timeout_reg;

  logic [N_REQ-1:0] req_rot;
  logic [GW-1:0]    pick_off;
  logic [GW:0]      pick_sum;
  logic [GW-1:0]    pick;
  logic [31:0]      sel_a, sel_b;
  logic             wait_expired;

  // Rotate requests so that bit 0 corresponds to rr_ptr, then take the lowest set bit.
  always_comb begin
    req_rot  = N_REQ'({req, req} >> rr_ptr_reg);
    pick_off = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = GW'(k);
    end
    pick_sum = {1'b0, rr_ptr_reg} + {1'b0, pick_off};
    if (pick_sum >= (GW+1)'(N_REQ)) pick = GW'(pick_sum - (GW+1)'(N_REQ));
    else                            pick = pick_sum[GW-1:0];
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick == GW'(k)) begin
        sel_a = op_a[32*k +: 32];
        sel_b = op_b[32*k +: 32];
      end
    end
  end

  assign wait_expired = (cnt_reg == CW'(TIMEOUT - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (|req) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (mul_ready || wait_expired) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= S_IDLE;
      rr_ptr_reg  <= '0;
      grant_reg   <= '0;
      cnt_reg     <= '0;
      mul_a_reg   <= '0;
      mul_b_reg   <= '0;
      result_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (|req) begin
            grant_reg   <= pick;
            mul_a_reg   <= sel_a;
            mul_b_reg   <= sel_b;
            timeout_reg <= 1'b0;
          end
        end
        S_ISSUE: cnt_reg <= '0;
        S_WAIT: begin
          if (mul_ready) begin
            result_reg  <= mul_result;
            timeout_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (wait_expired) begin
              result_reg  <= 32'h7FC0_0000;
              timeout_reg <= 1'b1;
            end
          end
        end
        default: begin
          if (grant_reg == GW'(N_REQ - 1)) rr_ptr_reg <= '0;
          else                             rr_ptr_reg <= grant_reg + 1'b1;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_done
      assign done[gi] = (state_reg == S_DONE) && (grant_reg == GW'(gi));
    end
  endgenerate

  assign busy      = (state_reg != S_IDLE);
  assign mul_start = (state_reg == S_ISSUE);
  assign err       = (state_reg == S_DONE) && timeout_reg;
  assign mul_a     = mul_a_reg;
  assign mul_b     = mul_b_reg;
  assign result    = result_reg;

endmodule

// File: tb/tb_float_mul_arbiter.sv
// Directed bench for float_mul_arbiter with a table-driven float_mul stand-in.
// Stand-in raises mul_ready four cycles after mul_start, matching the 3.0*2.0 example.
module tb_float_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [31:0]  a_arr [4];
  logic [31:0]  b_arr [4];
  logic [127:0] op_a, op_b;
  logic [3:0]   done;
  logic [31:0]  result, mul_a, mul_b, mul_result;
  logic         err, busy, mul_start, mul_ready;

  int n_cmp = 0;
  int n_bad = 0;
  int stub_cnt = -1;
  bit stub_en = 1'b1;
  int n;

  always #5 clk = ~clk;

  assign op_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
  assign op_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

  float_mul_arbiter #(.N_REQ(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .done(done), .result(result), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_ready(mul_ready)
  );

  // Hand-computed single-precision products for the operand pairs used below.
  function automatic logic [31:0] fmul_tab(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h4040_0000, 32'h4000_0000}: return 32'h40C0_0000;
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4000_0000;
      {32'h40A0_0000, 32'h3F00_0000}: return 32'h4020_0000;
      {32'h4000_0000, 32'h4000_0000}: return 32'h4080_0000;
      default:                        return 32'h0000_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    mul_ready <= 1'b0;
    if (mul_start && stub_en) begin
      stub_cnt   <= 2;
      mul_result <= fmul_tab(mul_a, mul_b);
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end else if (stub_cnt == 0) begin
      mul_ready <= 1'b1;
      stub_cnt  <= -1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_done(input int limit, output int cycles);
    cycles = 0;
    while (done == 4'b0 && cycles < limit) begin
      step();
      cycles++;
    end
    chk("done_seen", 32'(done != 4'b0), 32'd1);
  endtask

  initial begin
    mul_ready  = 1'b0;
    mul_result = '0;
    rst = 1'b0;
    req = 4'b0;
    a_arr[0] = 32'h3F80_0000; b_arr[0] = 32'h4000_0000;
    a_arr[1] = 32'h4040_0000; b_arr[1] = 32'h4000_0000;
    a_arr[2] = 32'h40A0_0000; b_arr[2] = 32'h3F00_0000;
    a_arr[3] = 32'h4000_0000; b_arr[3] = 32'h4000_0000;
    step(); step();
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_start", 32'(mul_start), 32'h0);
    chk("rst_result", result, 32'h0);
    rst = 1'b1;

    // Single request: 3.0 * 2.0 with five cycles from mul_start to done.
    req = 4'b0010;
    step();
    chk("t1_start", 32'(mul_start), 32'h1);
    chk("t1_busy",  32'(busy), 32'h1);
    chk("t1_mul_a", mul_a, 32'h4040_0000);
    chk("t1_mul_b", mul_b, 32'h4000_0000);
    a_arr[1] = 32'h0;
    step();
    chk("t1_start_lo", 32'(mul_start), 32'h0);
    wait_done(40, n);
    chk("t1_latency", 32'(n + 1), 32'd5);
    chk("t1_done",   32'(done), 32'b0010);
    chk("t1_result", result, 32'h40C0_0000);
    chk("t1_err",    32'(err), 32'h0);
    chk("t1_hold_a", mul_a, 32'h4040_0000);
    req = 4'b0;
    a_arr[1] = 32'h4040_0000;
    step();
    chk("t1_idle", 32'(busy), 32'h0);
    chk("t1_result_hold", result, 32'h40C0_0000);

    // Simultaneous 0 and 2 after reset, then 0 and 3 to expose rr_ptr=3.
    rst = 1'b0; step(); rst = 1'b1;
    req = 4'b0101;
    wait_done(40, n);
    chk("t2_first",  32'(done), 32'b0001);
    chk("t2_res0",   result, 32'h4000_0000);
    req = 4'b0100;
    step();
    wait_done(40, n);
    chk("t2_second", 32'(done), 32'b0100);
    chk("t2_res2",   result, 32'h4020_0000);
    req = 4'b1001;
    step();
    wait_done(40, n);
    chk("t2_rr3",    32'(done), 32'b1000);
    chk("t2_res3",   result, 32'h4080_0000);
    req = 4'b0001;
    step();
    wait_done(40, n);
    chk("t2_then0",  32'(done), 32'b0001);
    req = 4'b0;
    step();

    // All four held continuously: strict rotation 0,1,2,3,0.
    rst = 1'b0; step(); rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done(40, n);
      chk("t3_order", 32'(done), 32'(4'b0001 << (i % 4)));
      chk("t3_err",   32'(err), 32'h0);
      step();
      chk("t3_single", 32'(done), 32'h0);
    end
    req = 4'b0;
    while (busy) step();

    // No mul_ready: timeout after 15 WAIT cycles with a quiet NaN.
    stub_en = 1'b0;
    req = 4'b1000;
    step();
    chk("t4_start", 32'(mul_start), 32'h1);
    wait_done(40, n);
    chk("t4_wait_cycles", 32'(n), 32'd16);
    chk("t4_done",   32'(done), 32'b1000);
    chk("t4_err",    32'(err), 32'h1);
    chk("t4_result", result, 32'h7FC0_0000);
    req = 4'b0;
    step();
    chk("t4_idle", 32'(busy), 32'h0);
    chk("t4_err_lo", 32'(err), 32'h0);
    stub_en = 1'b1;

    // Reset mid-WAIT: silent abort, late mul_ready ignored, then normal service.
    req = 4'b0001;
    step();
    chk("t5_start", 32'(mul_start), 32'h1);
    step(); step();
    chk("t5_in_wait", 32'(busy), 32'h1);
    rst = 1'b0;
    req = 4'b0;
    step();
    rst = 1'b1;
    chk("t5_done",   32'(done), 32'h0);
    chk("t5_busy",   32'(busy), 32'h0);
    chk("t5_mul_a",  mul_a, 32'h0);
    chk("t5_mul_b",  mul_b, 32'h0);
    chk("t5_result", result, 32'h0);
    chk("t5_err",    32'(err), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_done", 32'({busy, done}), 32'h0);
    end
    req = 4'b0100;
    wait_done(40, n);
    chk("t5_new_done", 32'(done), 32'b0100);
    chk("t5_new_res",  result, 32'h4020_0000);
    req = 4'b0;
    step();

    // Requester 2 drops req right after its grant.
    req = 4'b0100;
    step();
    chk("t6_start", 32'(mul_start), 32'h1);
    req = 4'b0;
    step();
    wait_done(40, n);
    chk("t6_done",   32'(done), 32'b0100);
    chk("t6_result", result, 32'h4020_0000);
    step(); step(); step();
    chk("t6_no_regrant", 32'({busy, done}), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
